// File: rtl/seg_scan_capture_pkg.sv
// Shared definitions for the 7-segment scan capture path: segment patterns,
// the pattern-to-BCD decoder, and the frame FSM state type.
package seg_scan_pkg;

  // Segment patterns g..a, active-high, same set the display encoders drive
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // Code reported for any pattern that is not one of the ten digits
  localparam logic [3:0] ERR_CODE = 4'hF;

  typedef enum logic [1:0] {
    S_TENS = 2'd0,
    S_ONES = 2'd1,
    S_PUB  = 2'd2
  } state_e;

  // One sampled scan pair (dp dropped)
  typedef struct packed {
    logic [2:0] sel;
    logic [6:0] seg;
  } scan_t;

  typedef struct packed {
    logic       err;
    logic [3:0] code;
  } dec_t;

  function automatic dec_t seg_decode(input logic [6:0] pat);
    dec_t d;
    d.err = 1'b0;
    case (pat)
      SEG_0:   d.code = 4'd0;
      SEG_1:   d.code = 4'd1;
      SEG_2:   d.code = 4'd2;
      SEG_3:   d.code = 4'd3;
      SEG_4:   d.code = 4'd4;
      SEG_5:   d.code = 4'd5;
      SEG_6:   d.code = 4'd6;
      SEG_7:   d.code = 4'd7;
      SEG_8:   d.code = 4'd8;
      SEG_9:   d.code = 4'd9;
      default: begin
        d.code = ERR_CODE;
        d.err  = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Multiplexed scan bus: the display driver is the master, the capture block
// listens as the slave.
interface seg_scan_capture_if;
  logic [2:0] sel;
  logic [7:0] seg;

  modport master (output sel, output seg);
  modport slave  (input sel, input seg);
endinterface

// File: rtl/seg_scan_capture_stable_filter.sv
// Samples the scan bus once and strobes "accept" exactly once per run of
// STABLE_CYCLES consecutive identical samples.
module seg_stable_filter
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel,
  input  logic [6:0] seg,
  output logic       accept,
  output scan_t      pair
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [2:0] s_sel;
  logic [6:0] s_seg;
  scan_t      prev;
  logic [7:0] cnt;
  logic       same;

  assign pair   = '{sel: s_sel, seg: s_seg};
  assign same   = (pair == prev);
  // Fires only on the step to STABLE, so a long run is accepted once
  assign accept = same && (cnt == STABLE - 8'd1);

  // Input sample register plus a one-cycle history for the stability compare
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_sel <= '0;
      s_seg <= '0;
      prev  <= '0;
    end else begin
      s_sel <= sel;
      s_seg <= seg;
      prev  <= pair;
    end
  end

  // Saturating run-length counter; any change restarts it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (!same)
      cnt <= '0;
    else if (cnt != STABLE)
      cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Display monitor: rebuilds the tens/ones value from the scan bus, publishes
// it when it changes, and flags bad patterns, out-of-range digits and stale
// displays.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 1024,
  parameter logic [2:0]  SEL_TENS      = 3'b110,
  parameter logic [2:0]  SEL_ONES      = 3'b111
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_scan_capture_if.slave    scan,
  output logic [3:0]           digit_tens,
  output logic [3:0]           digit_ones,
  output logic [5:0]           value,
  output logic                 update,
  output logic                 pattern_err,
  output logic                 range_err,
  output logic                 stale
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  logic       accept;
  scan_t      pair;
  dec_t       dec;
  logic       is_tens, is_ones;
  state_e     state;
  logic [3:0] tens_hold, ones_hold;
  logic [5:0] frame_value;
  logic       frame_bad, frame_range, frame_new;
  logic [15:0] to_cnt;
  logic       unused_dp;

  // The decimal point carries no digit information
  assign unused_dp = scan.seg[7];

  seg_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filt (
    .clk    (clk),
    .rst    (rst),
    .sel    (scan.sel),
    .seg    (scan.seg[6:0]),
    .accept (accept),
    .pair   (pair)
  );

  assign dec     = seg_decode(pair.seg);
  assign is_tens = accept && (pair.sel == SEL_TENS);
  assign is_ones = accept && (pair.sel == SEL_ONES);

  // 6-bit arithmetic wraps naturally for error codes and oversized tens
  assign frame_value = 6'(tens_hold) * 6'd10 + 6'(ones_hold);
  assign frame_bad   = (tens_hold == ERR_CODE) || (ones_hold == ERR_CODE);
  assign frame_range = (tens_hold > 4'd5) || (ones_hold > 4'd9);
  assign frame_new   = {tens_hold, ones_hold} != {digit_tens, digit_ones};

  // Frame assembly: tens first, ones completes the frame, one publish cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_TENS;
      tens_hold <= '0;
      ones_hold <= '0;
    end else begin
      case (state)
        S_TENS: if (is_tens) begin
          tens_hold <= dec.code;
          state     <= S_ONES;
        end
        S_ONES: if (is_tens) begin
          tens_hold <= dec.code;
        end else if (is_ones) begin
          ones_hold <= dec.code;
          state     <= S_PUB;
        end
        default: state <= S_TENS;
      endcase
    end
  end

  // Publish on change only; pattern_err accumulates across every frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_tens  <= '0;
      digit_ones  <= '0;
      value       <= '0;
      update      <= 1'b0;
      pattern_err <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      update <= 1'b0;
      if (state == S_PUB) begin
        pattern_err <= pattern_err | frame_bad;
        if (frame_new) begin
          digit_tens <= tens_hold;
          digit_ones <= ones_hold;
          value      <= frame_value;
          range_err  <= frame_range;
          update     <= 1'b1;
        end
      end
    end
  end

  // Cycles since the last completed frame, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_cnt <= '0;
    else if (state == S_PUB)
      to_cnt <= '0;
    else if (to_cnt != 16'hFFFF)
      to_cnt <= to_cnt + 16'd1;
  end

  assign stale = (to_cnt >= TO_LIM);

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: directed frames plus random scan
// runs, with expected publishes queued by a frame-level reference model.
module tb_seg_scan_capture;

  localparam int STAB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit_tens, digit_ones;
  logic [5:0] value;
  logic       update, pattern_err, range_err, stale;

  seg_scan_capture_if scan();

  seg_scan_capture #(
    .STABLE_CYCLES(STAB), .TIMEOUT(1024), .SEL_TENS(3'b110), .SEL_ONES(3'b111)
  ) dut (
    .clk(clk), .rst(rst), .scan(scan),
    .digit_tens(digit_tens), .digit_ones(digit_ones), .value(value),
    .update(update), .pattern_err(pattern_err), .range_err(range_err),
    .stale(stale)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int o;
    int v;
    int rerr;
    int perr;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: frame-level view of the display
  int   m_have_tens, m_tens, m_pub_t, m_pub_o, m_perr;
  logic [9:0] last_pair;

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (pats[i] == p) return i;
    return 15;
  endfunction

  task automatic model_reset();
    m_have_tens = 0; m_tens = 0; m_pub_t = 0; m_pub_o = 0; m_perr = 0;
  endtask

  // A run is a digit only if held long enough; short runs are noise
  task automatic model_run(input logic [2:0] s, input logic [7:0] g, input int len);
    int code;
    exp_t e;
    if (len < STAB + 2) return;
    code = ref_decode(g[6:0]);
    if (s == 3'b110) begin
      m_tens = code;
      m_have_tens = 1;
    end else if (s == 3'b111 && m_have_tens != 0) begin
      m_have_tens = 0;
      if (m_tens == 15 || code == 15) m_perr = 1;
      if (m_tens != m_pub_t || code != m_pub_o) begin
        m_pub_t = m_tens;
        m_pub_o = code;
        e.t = m_tens; e.o = code; e.v = (m_tens * 10 + code) % 64;
        e.rerr = (m_tens > 5 || code > 9) ? 1 : 0;
        e.perr = m_perr;
        q.push_back(e);
      end
    end
  endtask

  task automatic run(input logic [2:0] s, input logic [7:0] g, input int len);
    model_run(s, g, len);
    last_pair = {s, g[6:0]};
    scan.sel = s;
    scan.seg = g;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int len);
    run(3'b000, 8'h00, len);
  endtask

  // Monitor: every update pulse must match the next queued publish
  always @(negedge clk) begin
    if (rst && update) begin
      if (q.size() == 0) begin
        chk("spurious_update", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("upd_tens",  int'(digit_tens),  e.t);
        chk("upd_ones",  int'(digit_ones),  e.o);
        chk("upd_value", int'(value),       e.v);
        chk("upd_range", int'(range_err),   e.rerr);
        chk("upd_patt",  int'(pattern_err), e.perr);
      end
    end
  end

  initial begin
    logic [2:0] s;
    logic [7:0] g;
    int len;

    rst = 1'b0;
    scan.sel = 3'b000;
    scan.seg = 8'h00;
    last_pair = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tens",   int'(digit_tens),  0);
    chk("rst_ones",   int'(digit_ones),  0);
    chk("rst_value",  int'(value),       0);
    chk("rst_update", int'(update),      0);
    chk("rst_patt",   int'(pattern_err), 0);
    chk("rst_range",  int'(range_err),   0);
    chk("rst_stale",  int'(stale),       0);
    rst = 1'b1;

    // Idle display goes stale around 1024 cycles
    repeat (1000) @(posedge clk);
    #1;
    chk("stale_early", int'(stale), 0);
    repeat (30) @(posedge clk);
    #1;
    chk("stale_set", int'(stale), 1);

    // Frame 00 equals reset value: clears stale without an update
    run(3'b110, 8'h3F, 8);
    run(3'b111, 8'h3F, 8);
    idle(4);
    chk("stale_clr", int'(stale), 0);
    chk("q_00", q.size(), 0);

    // Fresh start, frame 53
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run(3'b110, 8'h6D, 6);
    run(3'b111, 8'h4F, 6);
    idle(4);
    chk("f53_tens",  int'(digit_tens),  5);
    chk("f53_ones",  int'(digit_ones),  3);
    chk("f53_value", int'(value),       53);
    chk("f53_range", int'(range_err),   0);
    chk("f53_patt",  int'(pattern_err), 0);
    chk("q_53", q.size(), 0);

    // Same frame again: no publish
    run(3'b110, 8'h6D, 6);
    run(3'b111, 8'h4F, 6);
    idle(4);
    chk("rep_value", int'(value), 53);
    chk("rep_stale", int'(stale), 0);

    // Glitchy tens never accepted, so a lone ones run is ignored
    for (int i = 0; i < 5; i++) begin
      run(3'b110, 8'h06, 2);
      run(3'b110, 8'h07, 2);
    end
    run(3'b111, 8'h5B, 8);
    idle(4);
    chk("glitch_value", int'(value), 53);
    chk("q_glitch", q.size(), 0);

    // Tens 6, ones 'E'
    run(3'b110, 8'h7D, 8);
    run(3'b111, 8'h79, 8);
    idle(4);
    chk("e_tens",  int'(digit_tens),  6);
    chk("e_ones",  int'(digit_ones),  15);
    chk("e_value", int'(value),       11);
    chk("e_range", int'(range_err),   1);
    chk("e_patt",  int'(pattern_err), 1);

    // Valid frame 12: range clears, pattern_err sticks
    run(3'b110, 8'h06, 8);
    run(3'b111, 8'h5B, 8);
    idle(4);
    chk("f12_value", int'(value),       12);
    chk("f12_range", int'(range_err),   0);
    chk("f12_patt",  int'(pattern_err), 1);

    // Reset while holding tens=4
    run(3'b110, 8'h66, 8);
    rst = 1'b0;
    #1;
    chk("mid_tens",  int'(digit_tens),  0);
    chk("mid_value", int'(value),       0);
    chk("mid_patt",  int'(pattern_err), 0);
    chk("mid_stale", int'(stale),       0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    run(3'b111, 8'h6F, 8);
    idle(4);
    chk("mid_after_value", int'(value), 0);
    chk("q_mid", q.size(), 0);

    // Random scan runs, with some noise runs and unknown selects
    for (int i = 0; i < 120; i++) begin
      do begin
        int r;
        r = $urandom_range(0, 9);
        s = (r < 5) ? 3'b110 : (r < 9) ? 3'b111 : 3'($urandom_range(0, 5));
        if ($urandom_range(0, 99) < 85) g = {1'b0, pats[$urandom_range(0, 9)]};
        else g = 8'($urandom_range(0, 255));
        g[7] = 1'($urandom_range(0, 1));
      end while ({s, g[6:0]} == last_pair);
      len = ($urandom_range(0, 9) < 3) ? $urandom_range(1, STAB - 1)
                                       : $urandom_range(STAB + 2, STAB + 5);
      run(s, g, len);
    end
    idle(10);
    chk("rand_q_empty", q.size(),           0);
    chk("rand_tens",    int'(digit_tens),   m_pub_t);
    chk("rand_ones",    int'(digit_ones),   m_pub_o);
    chk("rand_patt",    int'(pattern_err),  m_perr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive side of the multiplexed 7-segment scan interface driven by the team's 0–59 counter/display blocks.
- Samples the sel/seg scan bus and decodes each segment pattern back to BCD.
- Reassembles the tens/ones pair into a binary value and flags malformed or stale frames.
- Used as an on-chip display monitor and as a self-check for display-driving blocks.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples needed before a digit is accepted (range 2..255).
- TIMEOUT, 1024: cycles without a completed frame before the stale flag is raised (range 16..65535).
- SEL_TENS, 3'b110: sel code that marks the tens digit.
- SEL_ONES, 3'b111: sel code that marks the ones digit.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous active-low reset
- sel  in  3  scan digit select, synchronous to clk
- seg  in  8  segment pattern, active-high; bit7 = dp (ignored), bits6..0 = g..a
- digit_tens  out  4  last published tens BCD
- digit_ones  out  4  last published ones BCD
- value  out  6  digit_tens*10 + digit_ones
- update  out  1  one-cycle pulse when value changes
- pattern_err  out  1  sticky; set when an undecodable pattern is accepted
- range_err  out  1  high while the published tens >5 or ones >9
- stale  out  1  high when no frame has completed for TIMEOUT cycles

Behaviour:
- Reset: all outputs 0; FSM in S_TENS; sample regs 0; stable counter 0; timeout counter 0.
- Input stage: sel and seg are registered once (s_sel, s_seg). All decisions use the registered copies.
- Stable counter:
  - Increments, saturating at STABLE_CYCLES, while {s_sel, s_seg[6:0]} equals the previous cycle's value.
  - Clears to 0 on any change.
  - A pair is "accepted" only on the cycle the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES. Each stable run is therefore accepted exactly once.
- Decode (combinational, shared function): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9. Every other pattern, including 79 ('E'), gives code 4'hF and err=1.
- Unknown sel (neither SEL_TENS nor SEL_ONES): the pair is still tracked by the stable counter but never accepted, and the FSM state is unchanged.
- FSM:
  - S_TENS: an accepted tens pair latches tens_hold and moves to S_ONES. An accepted ones pair is ignored.
  - S_ONES: an accepted ones pair latches ones_hold and moves to S_PUB. An accepted tens pair overwrites tens_hold and stays in S_ONES.
  - S_PUB (one cycle):
    - If {tens_hold, ones_hold} differs from the published digits, update digit_tens/digit_ones/value and pulse update in this same cycle. Otherwise update stays 0.
    - Return to S_TENS and clear the timeout counter.
- Latency: ones accepted on edge N → outputs and update valid after edge N+1 (S_PUB). Input change to acceptance takes STABLE_CYCLES+1 edges, counting the sample register.
- value arithmetic: 6-bit result. If either held digit is 4'hF or tens >5, value takes the low 6 bits of the sum and range_err is asserted. Digits publish regardless.
- pattern_err: sticky from the S_PUB cycle of any frame containing an err digit. Cleared only by reset.
- stale:
  - Timeout counter is 16 bits, saturating. It increments every cycle outside S_PUB.
  - stale = (counter >= TIMEOUT). It drops in the cycle after S_PUB.
- Simultaneous events: acceptance and timeout in the same cycle → acceptance wins and the counter still increments. Reset mid-frame discards the held digits.

Decomposition:
- Package seg_scan_pkg:
  - the seg-to-BCD decode function and the 10 pattern constants (shared with the existing display encoders);
  - the FSM state enum (S_TENS, S_ONES, S_PUB);
  - the ERR_CODE = 4'hF constant.
- One sub-module, seg_stable_filter: sample register, stable counter, and the accept strobe with the accepted sel/seg.

Test Plan:
- Reset, then drive sel 110/seg 6D for 6 cycles followed by sel 111/seg 4F for 6 cycles → update pulses once; digit_tens=5, digit_ones=3, value=53; no errors.
- Repeat the identical 53 frame → no update pulse; value holds 53; stale stays 0.
- Glitchy input with STABLE_CYCLES=4: seg alternates 06/07 every 2 cycles for 20 cycles → no acceptance, FSM stays S_TENS, outputs unchanged.
- Tens=7D (6), ones=79 ('E') → value published with digit_tens=6, digit_ones=F; range_err=1; pattern_err=1 and stays 1 after a later valid frame 12.
- No activity for 1024 cycles after reset → stale=1 at cycle 1024. A valid frame 00 clears stale the cycle after its S_PUB; update stays 0 because 00 equals the reset value.
- Assert rst low while in S_ONES holding tens=4 → all outputs 0 immediately; a subsequent ones-only frame (sel 111/seg 6F) produces no update.
